// File: rtl/neo_lb_pkg.sv
// Shared types and constants for the NEO-B1 sprite line-buffer writer.
package neo_lb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WR0,
        ST_ADV0,
        ST_WR1,
        ST_ADV1,
        ST_WR2,
        ST_ADV2,
        ST_WR3,
        ST_ADV3,
        ST_DLOAD
    } state_t;

    localparam logic [1:0] GRP1_A = 2'd0;
    localparam logic [1:0] GRP1_B = 2'd1;
    localparam logic [1:0] GRP2_A = 2'd2;
    localparam logic [1:0] GRP2_B = 2'd3;

    localparam logic [3:0] PIX_TRANSPARENT = 4'h0;

    // Place an A/B bit pair into the WE/CK lane map of the chosen buffer group.
    function automatic logic [3:0] grp_bits(input logic grp2, input logic a, input logic b);
        logic [3:0] m;
        m = '0;
        if (grp2) begin
            m[GRP2_A] = a;
            m[GRP2_B] = b;
        end else begin
            m[GRP1_A] = a;
            m[GRP1_B] = b;
        end
        return m;
    endfunction

endpackage

// File: rtl/neo_lb_pixsel.sv
// Pixel pair selector: picks pixels 2k/2k+1 of a sliver, applies optional
// horizontal flip and the odd-X A/B swap, and flags opaque pixels.
module neo_lb_pixsel
    import neo_lb_pkg::*;
(
    input  logic [31:0] data,
    input  logic        flip,
    input  logic        odd,
    input  logic [1:0]  pair,
    output logic [3:0]  gad,
    output logic [3:0]  gbd,
    output logic        a_opaque,
    output logic        b_opaque
);

    logic [2:0] lo_idx;
    logic [2:0] hi_idx;
    logic [3:0] lo_pix;
    logic [3:0] hi_pix;

    always_comb begin
        lo_idx = {pair, 1'b0};
        hi_idx = {pair, 1'b1};
        // Flipped order is pixel 7-i, which is the bitwise inverse of a 3-bit index.
        if (flip) begin
            lo_idx = ~lo_idx;
            hi_idx = ~hi_idx;
        end
        lo_pix   = data[{lo_idx, 2'b00} +: 4];
        hi_pix   = data[{hi_idx, 2'b00} +: 4];
        gad      = odd ? hi_pix : lo_pix;
        gbd      = odd ? lo_pix : hi_pix;
        a_opaque = (gad != PIX_TRANSPARENT);
        b_opaque = (gbd != PIX_TRANSPARENT);
    end

endmodule

// File: rtl/neo_lb_writer.sv
// Write-side driver for the NEO-B1 sprite line buffers (PBUS/GAD/GBD/WE/CK/LD/SS/TMS0).
// Optional feature: define NEO_LBW_HFLIP_EN to honour SPR_HFLIP.
module neo_lb_writer
    import neo_lb_pkg::*;
#(
    parameter logic [7:0] DISP_ADDR = 8'h00,
    parameter logic       SS_EN     = 1'b1
)(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        LINE_START,
    input  logic        PIX_CK_EN,
    input  logic        SPR_VALID,
    output logic        SPR_READY,
    input  logic [8:0]  SPR_X,
    input  logic [7:0]  SPR_PAL,
    input  logic [31:0] SPR_DATA,
    input  logic        SPR_HFLIP,
    output logic [23:0] PBUS,
    output logic [3:0]  GAD,
    output logic [3:0]  GBD,
    output logic [3:0]  WE,
    output logic [3:0]  CK,
    output logic        LD1,
    output logic        LD2,
    output logic        SS1,
    output logic        SS2,
    output logic        TMS0,
    output logic        OVERRUN
);

    state_t      state;
    state_t      nxt;
    logic [31:0] s_data;
    logic        s_odd;
    logic        flip;
    logic [1:0]  pair;
    logic        enter_wr;
    logic        in_wr;
    logic        busy;
    logic [7:0]  a_addr;
    logic [7:0]  b_addr;
    logic [3:0]  sel_gad;
    logic [3:0]  sel_gbd;
    logic        a_opaque;
    logic        b_opaque;
    logic [3:0]  disp_ck;
    logic [3:0]  wr_ck;
    logic [3:0]  wr_we;

`ifdef NEO_LBW_HFLIP_EN
    logic s_flip;
    assign flip = s_flip;
`else
    logic unused_hflip;
    assign unused_hflip = SPR_HFLIP;
    assign flip         = 1'b0;
`endif

    always_comb begin
        SPR_READY = nRST && (state == ST_IDLE) && !LINE_START;
        busy      = (state != ST_IDLE) && (state != ST_DLOAD);
        in_wr     = state inside {ST_WR0, ST_WR1, ST_WR2, ST_WR3};
        enter_wr  = state inside {ST_LOAD, ST_ADV0, ST_ADV1, ST_ADV2};
        b_addr    = SPR_X[8:1];
        a_addr    = SPR_X[8:1] + {7'd0, SPR_X[0]};
        disp_ck   = PIX_CK_EN ? grp_bits(TMS0, 1'b1, 1'b1) : '0;
        wr_ck     = in_wr ? grp_bits(~TMS0, 1'b1, 1'b1) : '0;
        wr_we     = grp_bits(~TMS0, a_opaque, b_opaque);
    end

    // Pair index is that of the WR state being entered, since outputs are registered.
    always_comb begin
        nxt  = ST_IDLE;
        pair = 2'd0;
        case (state)
            ST_IDLE:  nxt = SPR_VALID ? ST_LOAD : ST_IDLE;
            ST_LOAD:  nxt = ST_WR0;
            ST_WR0:   nxt = ST_ADV0;
            ST_ADV0:  begin nxt = ST_WR1; pair = 2'd1; end
            ST_WR1:   nxt = ST_ADV1;
            ST_ADV1:  begin nxt = ST_WR2; pair = 2'd2; end
            ST_WR2:   nxt = ST_ADV2;
            ST_ADV2:  begin nxt = ST_WR3; pair = 2'd3; end
            ST_WR3:   nxt = ST_ADV3;
            ST_ADV3:  nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end

    neo_lb_pixsel u_pixsel (
        .data     (s_data),
        .flip     (flip),
        .odd      (s_odd),
        .pair     (pair),
        .gad      (sel_gad),
        .gbd      (sel_gbd),
        .a_opaque (a_opaque),
        .b_opaque (b_opaque)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= ST_IDLE;
            TMS0    <= 1'b0;
            SS1     <= SS_EN;
            SS2     <= 1'b0;
            PBUS    <= '0;
            GAD     <= '0;
            GBD     <= '0;
            WE      <= '0;
            CK      <= '0;
            LD1     <= 1'b0;
            LD2     <= 1'b0;
            OVERRUN <= 1'b0;
            s_data  <= '0;
            s_odd   <= 1'b0;
`ifdef NEO_LBW_HFLIP_EN
            s_flip  <= 1'b0;
`endif
        end else begin
            PBUS    <= '0;
            GAD     <= '0;
            GBD     <= '0;
            WE      <= '0;
            CK      <= '0;
            LD1     <= 1'b0;
            LD2     <= 1'b0;
            OVERRUN <= 1'b0;
            if (LINE_START) begin
                // The group being written now becomes the displayed group.
                TMS0    <= ~TMS0;
                SS1     <= SS_EN & TMS0;
                SS2     <= SS_EN & ~TMS0;
                PBUS    <= {8'h00, DISP_ADDR, DISP_ADDR};
                LD1     <= TMS0;
                LD2     <= ~TMS0;
                OVERRUN <= busy;
                state   <= ST_DLOAD;
            end else begin
                state <= nxt;
                CK    <= disp_ck | wr_ck;
                if (state == ST_IDLE && SPR_VALID) begin
                    s_data <= SPR_DATA;
                    s_odd  <= SPR_X[0];
`ifdef NEO_LBW_HFLIP_EN
                    s_flip <= SPR_HFLIP;
`endif
                    PBUS   <= {SPR_PAL, b_addr, a_addr};
                    LD1    <= TMS0;
                    LD2    <= ~TMS0;
                end
                if (enter_wr) begin
                    GAD <= sel_gad;
                    GBD <= sel_gbd;
                    WE  <= wr_we;
                end
            end
        end
    end

endmodule

// File: tb/tb_neo_lb_writer.sv
// Self-checking bench for neo_lb_writer: sliver vector table plus hand-written
// line-start, readout, collision and reset sequences, checked via a per-cycle scoreboard.
module tb_neo_lb_writer;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        LINE_START;
    logic        PIX_CK_EN;
    logic        SPR_VALID;
    logic        SPR_READY;
    logic [8:0]  SPR_X;
    logic [7:0]  SPR_PAL;
    logic [31:0] SPR_DATA;
    logic        SPR_HFLIP;
    logic [23:0] PBUS;
    logic [3:0]  GAD;
    logic [3:0]  GBD;
    logic [3:0]  WE;
    logic [3:0]  CK;
    logic        LD1;
    logic        LD2;
    logic        SS1;
    logic        SS2;
    logic        TMS0;
    logic        OVERRUN;

    always #5 CLK = ~CLK;

    neo_lb_writer #(.DISP_ADDR(8'h00), .SS_EN(1'b1)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .LINE_START (LINE_START),
        .PIX_CK_EN  (PIX_CK_EN),
        .SPR_VALID  (SPR_VALID),
        .SPR_READY  (SPR_READY),
        .SPR_X      (SPR_X),
        .SPR_PAL    (SPR_PAL),
        .SPR_DATA   (SPR_DATA),
        .SPR_HFLIP  (SPR_HFLIP),
        .PBUS       (PBUS),
        .GAD        (GAD),
        .GBD        (GBD),
        .WE         (WE),
        .CK         (CK),
        .LD1        (LD1),
        .LD2        (LD2),
        .SS1        (SS1),
        .SS2        (SS2),
        .TMS0       (TMS0),
        .OVERRUN    (OVERRUN)
    );

    typedef struct packed {
        logic [23:0] pbus;
        logic [3:0]  gad;
        logic [3:0]  gbd;
        logic [3:0]  we;
        logic [3:0]  ck;
        logic        ld1;
        logic        ld2;
        logic        ss1;
        logic        ss2;
        logic        tms0;
        logic        overrun;
    } obs_t;

    typedef struct {
        obs_t  exp;
        string tag;
    } sb_t;

    typedef struct {
        string       name;
        logic [8:0]  x;
        logic [7:0]  pal;
        logic [31:0] data;
        logic        hflip;
        logic [23:0] pbus;
        logic [3:0]  gad0;
        logic [3:0]  gbd0;
    } vec_t;

    obs_t  act;
    sb_t   sb[$];
    vec_t  tbl[6];
    logic  tms;
    int    errors = 0;
    int    checks = 0;

    assign act = {PBUS, GAD, GBD, WE, CK, LD1, LD2, SS1, SS2, TMS0, OVERRUN};

    function automatic string fmt(input obs_t o);
        return $sformatf("pbus=%h gad=%h gbd=%h we=%b ck=%b ld1=%b ld2=%b ss1=%b ss2=%b tms0=%b ovr=%b",
                         o.pbus, o.gad, o.gbd, o.we, o.ck, o.ld1, o.ld2, o.ss1, o.ss2, o.tms0, o.overrun);
    endfunction

    function automatic obs_t idle_obs(input logic t);
        obs_t r;
        r      = '0;
        r.tms0 = t;
        r.ss1  = ~t;
        r.ss2  = t;
        return r;
    endfunction

    function automatic logic [3:0] grp(input logic g2, input logic a, input logic b);
        return g2 ? {b, a, 2'b00} : {2'b00, b, a};
    endfunction

    function automatic logic [3:0] pix(input logic [31:0] d, input logic fl, input int i);
        int j;
        j = fl ? 7 - i : i;
        return d[4*j +: 4];
    endfunction

    task automatic chk_obs(input string tag, input obs_t a, input obs_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %s | want %s", tag, fmt(a), fmt(e));
        end
    endtask

    task automatic chk_bit(input string tag, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %b want %b", tag, a, e);
        end
    endtask

    task automatic push(input obs_t r, input string tag);
        sb_t e;
        e.exp = r;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Expected per-cycle outputs from LOAD onward; only the first nrec cycles are queued.
    task automatic push_sliver(input vec_t v, input int unsigned nrec);
        obs_t        r;
        logic        g2;
        logic        fl;
        logic [3:0]  lo;
        logic [3:0]  hi;
        int unsigned n;
        g2 = ~tms;
`ifdef NEO_LBW_HFLIP_EN
        fl = v.hflip;
`else
        fl = 1'b0;
`endif
        n = 0;
        r = idle_obs(tms);
        r.pbus = v.pbus;
        r.ld1  = ~g2;
        r.ld2  = g2;
        if (n < nrec) push(r, {v.name, ".load"});
        n++;
        for (int k = 0; k < 4; k++) begin
            lo = pix(v.data, fl, 2*k);
            hi = pix(v.data, fl, 2*k + 1);
            r = idle_obs(tms);
            if (k == 0) begin
                r.gad = v.gad0;
                r.gbd = v.gbd0;
            end else begin
                r.gad = v.x[0] ? hi : lo;
                r.gbd = v.x[0] ? lo : hi;
            end
            r.we = grp(g2, r.gad != 4'h0, r.gbd != 4'h0);
            if (n < nrec) push(r, $sformatf("%s.wr%0d", v.name, k));
            n++;
            r = idle_obs(tms);
            r.ck = grp(g2, 1'b1, 1'b1);
            if (n < nrec) push(r, $sformatf("%s.adv%0d", v.name, k));
            n++;
        end
    endtask

    task automatic apply(input vec_t v);
        SPR_X     = v.x;
        SPR_PAL   = v.pal;
        SPR_DATA  = v.data;
        SPR_HFLIP = v.hflip;
    endtask

    task automatic wait_ready(input string tag);
        int unsigned n;
        n = 0;
        while (SPR_READY !== 1'b1 && n < 30) begin
            @(posedge CLK); #1;
            n++;
        end
        chk_bit({tag, ".ready_wait"}, SPR_READY, 1'b1);
    endtask

    task automatic drain(input string tag);
        int unsigned n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        chk_bit({tag, ".drained"}, sb.size() == 0, 1'b1);
    endtask

    task automatic run_sliver(input vec_t v);
        wait_ready(v.name);
        apply(v);
        SPR_VALID = 1'b1;
        @(posedge CLK); #1;
        SPR_VALID = 1'b0;
        push_sliver(v, 9);
        for (int i = 1; i <= 9; i++) begin
            @(posedge CLK); #1;
            chk_bit($sformatf("%s.ready_c%0d", v.name, i), SPR_READY, i == 9);
        end
        drain(v.name);
    endtask

    initial begin : monitor
        sb_t e;
        forever begin
            @(negedge CLK);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk_obs(e.tag, act, e.exp);
            end
        end
    end

    initial begin : watchdog
        #100000;
        errors++;
        $display("FAIL watchdog: got still running, want finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        obs_t r;
        vec_t v;

        tbl[0] = '{"x20",    9'd20,  8'h3C, 32'h87654321, 1'b0, 24'h3C0A0A, 4'h1, 4'h2};
        tbl[1] = '{"x21",    9'd21,  8'h3C, 32'h87654321, 1'b0, 24'h3C0A0B, 4'h2, 4'h1};
        tbl[2] = '{"sparse", 9'd20,  8'h55, 32'h0000F000, 1'b0, 24'h550A0A, 4'h0, 4'h0};
        tbl[3] = '{"x511",   9'd511, 8'h01, 32'h11111111, 1'b0, 24'h01FF00, 4'h1, 4'h1};
`ifdef NEO_LBW_HFLIP_EN
        tbl[4] = '{"hflip",  9'd20,  8'h3C, 32'h87654321, 1'b1, 24'h3C0A0A, 4'h8, 4'h7};
`else
        tbl[4] = '{"hflip",  9'd20,  8'h3C, 32'h87654321, 1'b1, 24'h3C0A0A, 4'h1, 4'h2};
`endif
        tbl[5] = '{"x256",   9'd256, 8'hAA, 32'hF0E0D0C0, 1'b0, 24'hAA8080, 4'h0, 4'hC};

        nRST       = 1'b0;
        LINE_START = 1'b0;
        PIX_CK_EN  = 1'b0;
        SPR_VALID  = 1'b0;
        SPR_X      = '0;
        SPR_PAL    = '0;
        SPR_DATA   = '0;
        SPR_HFLIP  = 1'b0;
        tms        = 1'b0;

        repeat (3) @(posedge CLK);
        #1;
        chk_obs("reset.obs", act, idle_obs(1'b0));
        chk_bit("reset.ready", SPR_READY, 1'b0);
        nRST = 1'b1;
        @(posedge CLK); #1;

        for (int i = 0; i < 6; i++) run_sliver(tbl[i]);

        // LINE_START during WR2 aborts the sliver and swaps the pairs.
        wait_ready("abort");
        apply(tbl[0]);
        SPR_VALID = 1'b1;
        @(posedge CLK); #1;
        SPR_VALID = 1'b0;
        push_sliver(tbl[0], 6);
        r = idle_obs(1'b1);
        r.ld2     = 1'b1;
        r.overrun = 1'b1;
        push(r, "abort.dload");
        for (int i = 0; i < 3; i++) push(idle_obs(1'b1), "abort.idle");
        repeat (5) @(posedge CLK);
        #1;
        LINE_START = 1'b1;
        @(posedge CLK); #1;
        LINE_START = 1'b0;
        tms = 1'b1;
        drain("abort");

        // Display readout now clocks group 2.
        PIX_CK_EN = 1'b1;
        @(posedge CLK); #1;
        PIX_CK_EN = 1'b0;
        r = idle_obs(1'b1);
        r.ck = 4'b1100;
        push(r, "pixck.read");
        push(idle_obs(1'b1), "pixck.idle");
        drain("pixck");

        v = tbl[1];
        v.name = "grp1_x21";
        run_sliver(v);

        // LINE_START, SPR_VALID and PIX_CK_EN together: no accept, readout suppressed.
        wait_ready("collide");
        apply(tbl[0]);
        SPR_VALID  = 1'b1;
        LINE_START = 1'b1;
        PIX_CK_EN  = 1'b1;
        #1;
        chk_bit("collide.ready", SPR_READY, 1'b0);
        @(posedge CLK); #1;
        SPR_VALID  = 1'b0;
        LINE_START = 1'b0;
        PIX_CK_EN  = 1'b0;
        tms = 1'b0;
        r = idle_obs(1'b0);
        r.ld1 = 1'b1;
        push(r, "collide.dload");
        push(idle_obs(1'b0), "collide.idle0");
        push(idle_obs(1'b0), "collide.idle1");
        drain("collide");
        chk_bit("collide.ready_after", SPR_READY, 1'b1);

        // Asynchronous reset in the middle of a sliver.
        wait_ready("rst_mid");
        apply(tbl[2]);
        SPR_VALID = 1'b1;
        @(posedge CLK); #1;
        SPR_VALID = 1'b0;
        push_sliver(tbl[2], 2);
        @(posedge CLK); #7;
        nRST = 1'b0;
        #1;
        chk_obs("rst_mid.obs", act, idle_obs(1'b0));
        chk_bit("rst_mid.ready", SPR_READY, 1'b0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(posedge CLK); #1;
        chk_obs("rst_mid.after", act, idle_obs(1'b0));
        chk_bit("rst_mid.ready_after", SPR_READY, 1'b1);

        drain("final");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
